// File: rtl/prog_fill_ctrl_if.sv
// Backing-RAM read handshake between the fill controller (master) and the
// program memory (slave).
interface prog_fill_ctrl_if #(
    parameter int AW = 10
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/prog_fill_ctrl.sv
// Two-bank switching program cache fill controller: demand fills on a miss and
// next-line prefetch when the last word of the active line is fetched.
module prog_fill_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int AW         = 10
) (
    input  logic                            clk,
    input  logic                            Reset,
    input  logic                            fetch_req,
    input  logic [AW-1:0]                   fetch_addr,
    output logic                            hit,
    output logic                            hit_bank,
    output logic [$clog2(LINE_WORDS)-1:0]   hit_idx,
    output logic                            stall,
    prog_fill_ctrl_if.master                mem,
    output logic                            fill_we,
    output logic                            fill_bank,
    output logic [$clog2(LINE_WORDS)-1:0]   fill_idx,
    output logic [31:0]                     fill_data
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int TW = AW - OW;
    localparam logic [OW-1:0] LAST_BEAT = OW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEMAND   = 2'd1,
        ST_PREFETCH = 2'd2
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [1:0][TW-1:0]     tag_r, tag_nxt_s;
    logic [1:0]             valid_r, valid_nxt_s;
    logic                   k_r, k_nxt_s;
    logic                   tgt_bank_r, tgt_bank_nxt_s;
    logic [TW-1:0]          tgt_line_r, tgt_line_nxt_s;
    logic [OW-1:0]          beat_r, beat_nxt_s;

    logic [TW-1:0]          fetch_line_s;
    logic [TW-1:0]          next_line_s;
    logic [1:0]             match_s;
    logic                   hit_s;
    logic                   hit_bank_s;
    logic                   miss_s;
    logic                   next_res_s;
    logic                   busy_s;
    logic                   beat_done_s;
    logic                   victim_s;

    assign fetch_line_s = fetch_addr[AW-1:OW];
    assign next_line_s  = fetch_line_s + TW'(1);
    assign match_s[0]   = valid_r[0] && (tag_r[0] == fetch_line_s);
    assign match_s[1]   = valid_r[1] && (tag_r[1] == fetch_line_s);
    assign hit_s        = fetch_req && (match_s != 2'b00);
    assign hit_bank_s   = match_s[1];
    assign miss_s       = fetch_req && !hit_s;
    assign next_res_s   = (valid_r[0] && (tag_r[0] == next_line_s)) ||
                          (valid_r[1] && (tag_r[1] == next_line_s));
    assign busy_s       = (state_r != ST_IDLE);
    assign beat_done_s  = busy_s && mem.mem_ack;
    assign victim_s     = ~k_r;

    assign hit          = hit_s;
    assign hit_bank     = hit_bank_s;
    assign hit_idx      = fetch_addr[OW-1:0];
    assign stall        = miss_s;

    assign mem.mem_req  = busy_s;
    assign mem.mem_addr = busy_s ? {tgt_line_r, beat_r} : {AW{1'b0}};

    assign fill_we      = beat_done_s;
    assign fill_bank    = tgt_bank_r;
    assign fill_idx     = beat_r;
    assign fill_data    = mem.mem_rdata;

    // Next-state and fill bookkeeping; the filling bank is held invalid so it never hits.
    always_comb begin
        state_nxt_s    = state_r;
        tag_nxt_s      = tag_r;
        valid_nxt_s    = valid_r;
        tgt_bank_nxt_s = tgt_bank_r;
        tgt_line_nxt_s = tgt_line_r;
        beat_nxt_s     = beat_r;
        if (hit_s) begin
            k_nxt_s = hit_bank_s;
        end else begin
            k_nxt_s = k_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (miss_s) begin
                    state_nxt_s             = ST_DEMAND;
                    tgt_bank_nxt_s          = victim_s;
                    tgt_line_nxt_s          = fetch_line_s;
                    valid_nxt_s[victim_s]   = 1'b0;
                    tag_nxt_s[victim_s]     = fetch_line_s;
                    beat_nxt_s              = {OW{1'b0}};
                end else if (hit_s && (fetch_addr[OW-1:0] == LAST_BEAT) && !next_res_s) begin
                    state_nxt_s             = ST_PREFETCH;
                    tgt_bank_nxt_s          = ~hit_bank_s;
                    tgt_line_nxt_s          = next_line_s;
                    valid_nxt_s[~hit_bank_s] = 1'b0;
                    tag_nxt_s[~hit_bank_s]  = next_line_s;
                    beat_nxt_s              = {OW{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DEMAND, ST_PREFETCH: begin
                if (beat_done_s) begin
                    if (beat_r == LAST_BEAT) begin
                        valid_nxt_s[tgt_bank_r] = 1'b1;
                        state_nxt_s             = ST_IDLE;
                        beat_nxt_s              = {OW{1'b0}};
                    end else if ((state_r == ST_PREFETCH) && miss_s &&
                                 (fetch_line_s != tgt_line_r)) begin
                        // Redirect the prefetch bank to the demanded line once the beat lands.
                        state_nxt_s             = ST_DEMAND;
                        tgt_line_nxt_s          = fetch_line_s;
                        tag_nxt_s[tgt_bank_r]   = fetch_line_s;
                        beat_nxt_s              = {OW{1'b0}};
                    end else begin
                        beat_nxt_s = beat_r + OW'(1);
                    end
                end else begin
                    beat_nxt_s = beat_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset; a reset mid-fill abandons the line.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_r    <= ST_IDLE;
            tag_r[0]   <= {TW{1'b0}};
            tag_r[1]   <= TW'(1);
            valid_r    <= 2'b00;
            k_r        <= 1'b0;
            tgt_bank_r <= 1'b0;
            tgt_line_r <= {TW{1'b0}};
            beat_r     <= {OW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            tag_r      <= tag_nxt_s;
            valid_r    <= valid_nxt_s;
            k_r        <= k_nxt_s;
            tgt_bank_r <= tgt_bank_nxt_s;
            tgt_line_r <= tgt_line_nxt_s;
            beat_r     <= beat_nxt_s;
        end
    end
endmodule
